sipo_deser: RTL and testbench
=============================

Name: sipo_deser

Overview:
- Serial-to-parallel deserializer. It sits directly downstream of the serial-in/serial-out shift register (registru2) and consumes its serial output bit O.
- Collects WIDTH valid serial bits into a parallel word.
- Presents the word on a valid/ready interface through a one-entry holding register.
- Flags words lost to back-pressure.
- Provides a frame-sync input to realign word boundaries.

Parameters:
- WIDTH, 8: bits per parallel word; legal range 2..32.
- MSB_FIRST, 1: 1 = first received bit lands in par_data[WIDTH-1]; 0 = first received bit lands in par_data[0].

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- ser_in  in  1  serial data bit (registru2 output O).
- ser_valid  in  1  ser_in is sampled this cycle when high.
- sof  in  1  start-of-frame: realigns the word boundary.
- par_data  out  WIDTH  assembled word; stable while par_valid=1.
- par_valid  out  1  holding register contains a word.
- par_ready  in  1  consumer accepts the word this cycle when par_valid & par_ready.
- bit_cnt  out  $clog2(WIDTH)  number of bits currently collected in the shift register.
- overflow  out  1  sticky: a completed word was dropped.
- clr_ovf  in  1  clears overflow.

Behaviour:
- Reset (rst_n=0 at a rising edge) clears:
  - shift register, bit_cnt and par_data to 0;
  - par_valid and overflow to 0;
  - FSM to IDLE.
- Reset mid-word discards the partial word. Reset takes priority over every other input.
- FSM states:
  - IDLE: bit_cnt=0.
  - SHIFT: 0 < bit_cnt < WIDTH.
- FSM transitions:
  - IDLE -> SHIFT on ser_valid.
  - SHIFT -> IDLE when the WIDTH-th bit is sampled, or on sof.
- Shift rule:
  - MSB_FIRST=1: shreg <= {shreg[WIDTH-2:0], ser_in}.
  - MSB_FIRST=0: shreg <= {ser_in, shreg[WIDTH-1:1]}.
  - bit_cnt increments on each sampled bit.
- Word completion: occurs when ser_valid=1 and bit_cnt=WIDTH-1.
  - The assembled word, including the current bit, goes to the holding register.
  - bit_cnt wraps to 0.
  - par_valid=1 in the next cycle, so latency is 1 clk from the last bit sample to par_valid.
- Holding register:
  - Loads on completion if it is empty, or if it is drained in the same cycle (par_valid & par_ready). No word is lost in the simultaneous case.
  - If it is full and not drained at completion: the new word is dropped, the held word is kept, and overflow <= 1.
  - Drain without completion: par_valid <= 0 next cycle; par_data holds its last value.
- sof:
  - sof=1 with ser_valid=0: bit_cnt <= 0 and the partial word is discarded.
  - sof=1 with ser_valid=1: the current bit becomes bit 0 of a new word and bit_cnt <= 1.
  - sof never affects the holding register.
- overflow: set on a dropped word, cleared by clr_ovf. If set and clear occur in the same cycle, set wins.
- ser_valid=0 holds all shift state.
- par_ready is ignored while par_valid=0.

Decomposition:
- Package sipo_pkg holds:
  - the state enum {IDLE, SHIFT};
  - localparam CNT_W = $clog2(WIDTH), exposed as a function of WIDTH;
  - default WIDTH constant.
- Sub-module hold_reg: a one-entry valid/ready register with load, drain and drop/overflow outputs. It is reused later by the parallel-to-serial serializer stage.

Test Plan:
1. Reset then stimulus: WIDTH=8, MSB_FIRST=1, par_ready=1, send 1,0,1,1,0,0,1,0 with ser_valid=1 -> par_valid=1 one clk after the 8th bit, par_data=8'hB2, bit_cnt=0, overflow=0.
2. Bit order: MSB_FIRST=0, same bit sequence -> par_data=8'h4D.
3. Back-pressure and drop: par_ready=0, stream 3 words A5, 3C, FF -> par_data stays A5; overflow=1 after the 2nd completion. Then assert clr_ovf -> overflow=0 next clk.
4. Simultaneous drain and completion: hold word 0x11, then assert par_ready in the exact cycle the 8th bit of 0x22 is sampled -> 0x11 is accepted, par_data=0x22 and par_valid stays 1, overflow=0.
5. Realign with sof: after 3 bits, pulse sof with ser_valid=1 and ser_in=1, then send 7 more bits 0,0,0,0,0,0,1 -> par_data=0x81; the 3 earlier bits are discarded.
6. Reset mid-word: after 5 bits, drive rst_n=0 for 1 clk -> bit_cnt=0 and par_valid=0. The next 8 bits (value 0xF0) produce exactly 0xF0.

Source files
------------

// File: rtl/sipo_pkg.sv
// Shared types and sizing helpers for the serial-to-parallel deserializer.
package sipo_pkg;

    localparam int unsigned DefaultWidth = 8;

    typedef enum logic {
        StIdle,
        StShift
    } state_e;

    // Width of the bit counter for a given word width.
    function automatic int unsigned cnt_w(input int unsigned width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/sipo_deser_if.sv
// Serial input / parallel output bundle of the deserializer.
interface sipo_deser_if
    import sipo_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
);
    localparam int unsigned CntW = cnt_w(WIDTH);

    logic             ser_in;
    logic             ser_valid;
    logic             sof;
    logic [WIDTH-1:0] par_data;
    logic             par_valid;
    logic             par_ready;
    logic [CntW-1:0]  bit_cnt;
    logic             overflow;
    logic             clr_ovf;

    // Upstream source / downstream consumer side.
    modport master (
        output ser_in, ser_valid, sof, par_ready, clr_ovf,
        input  par_data, par_valid, bit_cnt, overflow
    );

    // Deserializer side.
    modport slave (
        input  ser_in, ser_valid, sof, par_ready, clr_ovf,
        output par_data, par_valid, bit_cnt, overflow
    );

endinterface

// File: rtl/sipo_deser_hold_reg.sv
// One-entry valid/ready holding register with a sticky overflow flag.
module hold_reg #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             ready_i,
    input  logic             clr_ovf_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    output logic             overflow_o
);

    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             ovf_q, ovf_d;
    logic             drain;
    logic             drop;

    // Next state: a drain in the same cycle frees the slot for an incoming word.
    always_comb begin
        drain   = valid_q & ready_i;
        drop    = load_i & valid_q & ~drain;
        data_d  = data_q;
        valid_d = valid_q;
        if (load_i && !drop) begin
            data_d  = data_i;
            valid_d = 1'b1;
        end else if (drain) begin
            valid_d = 1'b0;
        end
        // A drop in the same cycle as a clear keeps the flag set.
        ovf_d = ovf_q;
        if (drop) begin
            ovf_d = 1'b1;
        end else if (clr_ovf_i) begin
            ovf_d = 1'b0;
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
        end
    end

    assign data_o     = data_q;
    assign valid_o    = valid_q;
    assign overflow_o = ovf_q;

endmodule

// File: rtl/sipo_deser.sv
// Serial-to-parallel deserializer: collects WIDTH valid bits into a word and
// hands it to a one-entry holding register; sof realigns the word boundary.
module sipo_deser
    import sipo_pkg::*;
#(
    parameter int unsigned WIDTH     = DefaultWidth,
    parameter bit          MSB_FIRST = 1'b1
) (
    input logic         clk,
    input logic         rst_n,
    sipo_deser_if.slave bus
);

    localparam int unsigned CntW = cnt_w(WIDTH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] shift_next;
    logic [WIDTH-1:0] first_bit_word;
    logic             word_done;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: IDLE while no bits are collected, SHIFT otherwise.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (bus.ser_valid) begin
                    state_d = StShift;
                end
            end
            StShift: begin
                if (bus.sof && !bus.ser_valid) begin
                    state_d = StIdle;
                end else if (word_done) begin
                    state_d = StIdle;
                end
            end
        endcase
    end

    // FSM outputs: shifted word, completion strobe and bit count.
    always_comb begin
        shift_next     = MSB_FIRST ? {shreg_q[WIDTH-2:0], bus.ser_in}
                                   : {bus.ser_in, shreg_q[WIDTH-1:1]};
        first_bit_word = MSB_FIRST ? {{(WIDTH-1){1'b0}}, bus.ser_in}
                                   : {bus.ser_in, {(WIDTH-1){1'b0}}};
        // sof with a valid bit starts a new word, so it never completes one.
        word_done      = bus.ser_valid & ~bus.sof & (cnt_q == CntW'(WIDTH - 1));
        bus.bit_cnt    = cnt_q;
    end

    // Shift register and bit counter next state.
    always_comb begin
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        if (bus.sof) begin
            if (bus.ser_valid) begin
                shreg_d = first_bit_word;
                cnt_d   = CntW'(1);
            end else begin
                shreg_d = '0;
                cnt_d   = '0;
            end
        end else if (bus.ser_valid) begin
            shreg_d = shift_next;
            cnt_d   = word_done ? '0 : cnt_q + CntW'(1);
        end
    end

    // Shift register and bit counter state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

    hold_reg #(
        .WIDTH (WIDTH)
    ) u_hold_reg (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (word_done),
        .data_i     (shift_next),
        .ready_i    (bus.par_ready),
        .clr_ovf_i  (bus.clr_ovf),
        .data_o     (bus.par_data),
        .valid_o    (bus.par_valid),
        .overflow_o (bus.overflow)
    );

endmodule

// File: tb/tb_sipo_deser.sv
// Bench for sipo_deser: MSB-first and LSB-first instances share one stimulus
// stream and are compared every cycle against a queue-based word model.
module tb_sipo_deser;

    localparam int unsigned W = 8;

    logic clk = 1'b0;
    logic rst_n;

    sipo_deser_if #(.WIDTH(W)) bus_m ();
    sipo_deser_if #(.WIDTH(W)) bus_l ();

    sipo_deser #(.WIDTH(W), .MSB_FIRST(1'b1)) u_dut_msb (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_m)
    );

    sipo_deser #(.WIDTH(W), .MSB_FIRST(1'b0)) u_dut_lsb (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_l)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    bit           bits[$];
    logic         m_valid;
    logic [W-1:0] m_data_m;
    logic [W-1:0] m_data_l;
    logic         m_ovf;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_update(input bit b, input bit sv, input bit sof, input bit rdy,
                                input bit clr, input bit rstn);
        bit           done;
        bit           drain;
        bit           drop;
        logic [W-1:0] wm;
        logic [W-1:0] wl;
        done = 1'b0;
        wm   = '0;
        wl   = '0;
        if (!rstn) begin
            bits.delete();
            m_valid  = 1'b0;
            m_data_m = '0;
            m_data_l = '0;
            m_ovf    = 1'b0;
        end else begin
            drain = m_valid && rdy;
            if (sof) bits.delete();
            if (sv) begin
                bits.push_back(b);
                if (bits.size() == W) begin
                    done = 1'b1;
                    for (int i = 0; i < int'(W); i++) begin
                        wm[int'(W) - 1 - i] = bits[i];
                        wl[i]               = bits[i];
                    end
                    bits.delete();
                end
            end
            drop = done && m_valid && !drain;
            if (done && !drop) begin
                m_valid  = 1'b1;
                m_data_m = wm;
                m_data_l = wl;
            end else if (drain) begin
                m_valid = 1'b0;
            end
            if (drop) m_ovf = 1'b1;
            else if (clr) m_ovf = 1'b0;
        end
    endtask

    task automatic step(input bit b, input bit sv, input bit sof, input bit rdy,
                        input bit clr, input bit rstn);
        rst_n           = rstn;
        bus_m.ser_in    = b;
        bus_m.ser_valid = sv;
        bus_m.sof       = sof;
        bus_m.par_ready = rdy;
        bus_m.clr_ovf   = clr;
        bus_l.ser_in    = b;
        bus_l.ser_valid = sv;
        bus_l.sof       = sof;
        bus_l.par_ready = rdy;
        bus_l.clr_ovf   = clr;
        @(posedge clk);
        model_update(b, sv, sof, rdy, clr, rstn);
        #1;
        check("msb_valid", 32'(bus_m.par_valid), 32'(m_valid));
        check("msb_data", 32'(bus_m.par_data), 32'(m_data_m));
        check("msb_cnt", 32'(bus_m.bit_cnt), bits.size());
        check("msb_ovf", 32'(bus_m.overflow), 32'(m_ovf));
        check("lsb_valid", 32'(bus_l.par_valid), 32'(m_valid));
        check("lsb_data", 32'(bus_l.par_data), 32'(m_data_l));
        check("lsb_ovf", 32'(bus_l.overflow), 32'(m_ovf));
    endtask

    // Sends an MSB-first-ordered byte; par_ready may differ on the last bit.
    task automatic send_word(input logic [7:0] val, input bit rdy_rest, input bit rdy_last);
        logic [7:0] v;
        v = val;
        for (int i = 7; i >= 0; i--) begin
            step(v[i], 1'b1, 1'b0, (i == 0) ? rdy_last : rdy_rest, 1'b0, 1'b1);
        end
    endtask

    initial begin
        logic [7:0] seq1;
        bit         rb;
        seq1 = 8'b1011_0010;

        // Reset.
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("rst_valid", 32'(bus_m.par_valid), 32'd0);
        check("rst_cnt", 32'(bus_m.bit_cnt), 32'd0);
        check("rst_ovf", 32'(bus_m.overflow), 32'd0);
        check("rst_data", 32'(bus_m.par_data), 32'd0);

        // Basic word, both bit orders.
        for (int i = 7; i >= 0; i--) begin
            if (i == 0) check("pre_last_valid", 32'(bus_m.par_valid), 32'd0);
            step(seq1[i], 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        end
        check("t1_valid", 32'(bus_m.par_valid), 32'd1);
        check("t1_data_msb", 32'(bus_m.par_data), 32'hB2);
        check("t2_data_lsb", 32'(bus_l.par_data), 32'h4D);
        check("t1_cnt", 32'(bus_m.bit_cnt), 32'd0);
        check("t1_ovf", 32'(bus_m.overflow), 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        check("t1_drained", 32'(bus_m.par_valid), 32'd0);
        check("t1_data_kept", 32'(bus_m.par_data), 32'hB2);

        // Back-pressure and drop.
        send_word(8'hA5, 1'b0, 1'b0);
        check("t3_first", 32'(bus_m.par_data), 32'hA5);
        check("t3_ovf0", 32'(bus_m.overflow), 32'd0);
        send_word(8'h3C, 1'b0, 1'b0);
        check("t3_ovf1", 32'(bus_m.overflow), 32'd1);
        send_word(8'hFF, 1'b0, 1'b0);
        check("t3_kept", 32'(bus_m.par_data), 32'hA5);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        check("t3_clr", 32'(bus_m.overflow), 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);

        // Drain and completion in the same cycle.
        send_word(8'h11, 1'b0, 1'b0);
        check("t4_held", 32'(bus_m.par_data), 32'h11);
        send_word(8'h22, 1'b0, 1'b1);
        check("t4_data", 32'(bus_m.par_data), 32'h22);
        check("t4_valid", 32'(bus_m.par_valid), 32'd1);
        check("t4_ovf", 32'(bus_m.overflow), 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);

        // Realign with sof.
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        check("t5_cnt_after_sof", 32'(bus_m.bit_cnt), 32'd1);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        check("t5_data", 32'(bus_m.par_data), 32'h81);
        check("t5_valid", 32'(bus_m.par_valid), 32'd1);

        // Reset mid-word.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        check("t6_cnt", 32'(bus_m.bit_cnt), 32'd0);
        check("t6_valid", 32'(bus_m.par_valid), 32'd0);
        send_word(8'hF0, 1'b1, 1'b1);
        check("t6_data", 32'(bus_m.par_data), 32'hF0);

        // Randomized traffic against the model.
        for (int n = 0; n < 600; n++) begin
            rb = 1'($urandom_range(0, 1));
            step(rb,
                 $urandom_range(0, 9) < 7,
                 $urandom_range(0, 19) == 0,
                 $urandom_range(0, 1) == 1,
                 $urandom_range(0, 19) == 0,
                 $urandom_range(0, 63) != 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
